// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing one registered LED bank between N_REQ requesters.
// A grant is released when its owner drops req or after MAX_HOLD writes.
module led_share_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_HOLD  = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       led_out,
  output logic                   busy,
  output logic                   timeout
);

  localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  state_e            r_state, w_state_next;
  logic [N_REQ-1:0]  r_gnt, w_gnt_next;
  logic [IdxW-1:0]   r_owner, w_owner_next;
  logic [IdxW-1:0]   r_last, w_last_next;
  logic [HoldW-1:0]  r_hold, w_hold_next;
  logic [WIDTH-1:0]  r_led, w_led_next;
  logic              r_timeout, w_timeout_next;

  logic              w_any;
  logic [IdxW-1:0]   w_winner;
  logic [IdxW-1:0]   w_idx;
  logic              w_owner_req;
  logic [WIDTH-1:0]  w_owner_data;

  // Rotating search: first set req bit starting just after the last winner.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_idx = IdxW'((32'(r_last) + i) % N_REQ);
      if (!w_any && req[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_owner_req  = 1'b0;
    w_owner_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_owner == IdxW'(i)) begin
        w_owner_req  = req[i];
        w_owner_data = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_gnt_next     = '0;
    w_owner_next   = r_owner;
    w_last_next    = r_last;
    w_hold_next    = r_hold;
    w_led_next     = r_led;
    w_timeout_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_next = StGrant;
          w_gnt_next   = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_owner_next = w_winner;
          w_hold_next  = '0;
        end
      end
      StGrant: begin
        w_gnt_next = r_gnt;
        if (w_owner_req) begin
          w_led_next  = w_owner_data;
          w_hold_next = r_hold + 1'b1;
          // Last permitted write: force release so others are not starved.
          if (r_hold == HoldW'(MAX_HOLD - 1)) begin
            w_state_next   = StRelease;
            w_gnt_next     = '0;
            w_timeout_next = 1'b1;
          end
        end else begin
          w_state_next = StRelease;
          w_gnt_next   = '0;
        end
      end
      StRelease: begin
        w_last_next  = r_owner;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= StIdle;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_last    <= IdxW'(N_REQ - 1);
      r_hold    <= '0;
      r_led     <= RESET_VAL;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_gnt     <= w_gnt_next;
      r_owner   <= w_owner_next;
      r_last    <= w_last_next;
      r_hold    <= w_hold_next;
      r_led     <= w_led_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign gnt     = r_gnt;
  assign led_out = r_led;
  assign busy    = (r_state == StGrant);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed self-checking bench for led_share_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=16).
module tb_led_share_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [7:0]  led_out;
  logic        busy;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  led_share_arbiter #(
    .N_REQ    (4),
    .WIDTH    (8),
    .MAX_HOLD (16),
    .RESET_VAL(8'h00)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req    (req),
    .wr_data(wr_data),
    .gnt    (gnt),
    .led_out(led_out),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      req = 4'($urandom);
      step();
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt c%0d: got %b want 0000", c, gnt); end
      n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL reset_led c%0d: got %h want 00", c, led_out); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout c%0d: got %b want 0", c, timeout); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy); end
    end
    sys_rst = 1'b0;
    req = 4'b0000;
    step();
  endtask

  task automatic test_single();
    wr_data = 32'h00A5_0000;
    req = 4'b0100;
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt_first: got %b want 0100", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL single_led_first: got %h want 00", led_out); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt c%0d: got %b want 0100", c, gnt); end
      n_cmp++; if (led_out !== 8'hA5) begin n_err++; $display("FAIL single_led c%0d: got %h want a5", c, led_out); end
    end
    req = 4'b0000;
    step();
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_rel_gnt: got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_rel_busy: got %b want 0", busy); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL single_rel_timeout: got %b want 0", timeout); end
    step();
    n_cmp++; if (led_out !== 8'hA5) begin n_err++; $display("FAIL single_led_hold: got %h want a5", led_out); end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_data [4];
    logic [3:0] exp_gnt;
    int         k;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    wr_data = 32'h4433_2211;
    req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      k = g % 4;
      exp_gnt = 4'b0001 << k;
      for (int c = 0; c < 16; c++) begin
        n_cmp++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rot_gnt g%0d c%0d: got %b want %b", g, c, gnt, exp_gnt); end
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rot_timeout_grant g%0d c%0d: got %b want 0", g, c, timeout); end
        if (c > 0) begin
          n_cmp++; if (led_out !== exp_data[k]) begin n_err++; $display("FAIL rot_led g%0d c%0d: got %h want %h", g, c, led_out, exp_data[k]); end
        end
        step();
      end
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rot_rel_gnt g%0d: got %b want 0000", g, gnt); end
      n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL rot_rel_timeout g%0d: got %b want 1", g, timeout); end
      n_cmp++; if (led_out !== exp_data[k]) begin n_err++; $display("FAIL rot_rel_led g%0d: got %h want %h", g, led_out, exp_data[k]); end
      step();
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rot_idle_gnt g%0d: got %b want 0000", g, gnt); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rot_idle_timeout g%0d: got %b want 0", g, timeout); end
      if (g == 4) req = 4'b0000;
      step();
    end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rot_end_gnt: got %b want 0000", gnt); end
  endtask

  task automatic test_simultaneous();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    wr_data = 32'h3C00_1C00;
    req = 4'b0010;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL sim_pre_gnt: got %b want 0010", gnt); end
    req = 4'b0000;
    step();
    step();
    req = 4'b1010;
    step();
    n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL sim_first_gnt: got %b want 1000", gnt); end
    req = 4'b0010;
    step();
    n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL sim_nowrite_led: got %h want 00", led_out); end
    step();
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL sim_second_gnt: got %b want 0010", gnt); end
    step();
    n_cmp++; if (led_out !== 8'h1C) begin n_err++; $display("FAIL sim_second_led: got %h want 1c", led_out); end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_drop_first();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    wr_data = 32'h0088_775A;
    req = 4'b0001;
    step();
    step();
    n_cmp++; if (led_out !== 8'h5A) begin n_err++; $display("FAIL drop_setup_led: got %h want 5a", led_out); end
    req = 4'b0000;
    step();
    step();
    req = 4'b0110;
    step();
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL drop_gnt1: got %b want 0010", gnt); end
    req = 4'b0100;
    step();
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL drop_rel_gnt: got %b want 0000", gnt); end
    n_cmp++; if (led_out !== 8'h5A) begin n_err++; $display("FAIL drop_rel_led: got %h want 5a", led_out); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL drop_rel_timeout: got %b want 0", timeout); end
    step();
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL drop_idle_gnt: got %b want 0000", gnt); end
    step();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL drop_gnt2: got %b want 0100", gnt); end
    step();
    n_cmp++; if (led_out !== 8'h88) begin n_err++; $display("FAIL drop_led2: got %h want 88", led_out); end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_mid_reset();
    wr_data = 32'h0000_00FF;
    req = 4'b0001;
    step();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL midrst_gnt: got %b want 0001", gnt); end
    for (int c = 0; c < 5; c++) step();
    n_cmp++; if (led_out !== 8'hFF) begin n_err++; $display("FAIL midrst_led_pre: got %h want ff", led_out); end
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_gnt_after: got %b want 0000", gnt); end
    n_cmp++; if (led_out !== 8'h00) begin n_err++; $display("FAIL midrst_led_after: got %h want 00", led_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    req = 4'b1001;
    step();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL midrst_regrant: got %b want 0001", gnt); end
    req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    sys_rst = 1'b1;
    req     = 4'b0000;
    wr_data = '0;
    test_reset();
    test_single();
    test_rotation();
    test_simultaneous();
    test_drop_first();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
